// File: rtl/reg_file_sb.sv
// Register file with a per-word scoreboard. Reads are combinational, with optional
// write forwarding. A word reserved for a future write reads as busy until it is written.
module reg_file_sb #(
  parameter int DW       = 32,
  parameter int RAW      = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic [NRD*RAW-1:0] rd_addr_i,
  output logic [NRD*DW-1:0]  rd_data_o,
  output logic [NRD-1:0]     rd_busy_o,
  input  logic               wen_i,
  input  logic [RAW-1:0]     waddr_i,
  input  logic [DW-1:0]      wdata_i,
  input  logic               rsv_i,
  input  logic [RAW-1:0]     rsv_addr_i,
  output logic               rsv_ok_o,
  output logic [RAW:0]       busy_cnt_o
);

  localparam int DEPTH = 1 << RAW;

  logic [DW-1:0]    mem_reg [DEPTH];
  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;
  logic [RAW:0]     busy_cnt_reg;
  logic [RAW:0]     busy_cnt_next;

  logic wr_en;
  logic set_en;
  logic cnt_inc;
  logic cnt_dec;

  always_comb begin
    wr_en    = wen_i && !((ZERO_REG != 0) && (waddr_i == '0));
    rsv_ok_o = rsv_i && !rst_i &&
               (!busy_reg[rsv_addr_i] || (wen_i && (waddr_i == rsv_addr_i)));
    set_en   = rsv_ok_o && !((ZERO_REG != 0) && (rsv_addr_i == '0));

    // The set is applied after the clear, so a same-word write plus reserve leaves the word busy.
    busy_next = busy_reg;
    if (wr_en) begin
      busy_next[waddr_i] = 1'b0;
    end
    if (set_en) begin
      busy_next[rsv_addr_i] = 1'b1;
    end

    // The count is tracked incrementally: a bit only counts when it actually flips.
    cnt_inc       = set_en && !busy_reg[rsv_addr_i];
    cnt_dec       = wr_en && busy_reg[waddr_i] && !(set_en && (rsv_addr_i == waddr_i));
    busy_cnt_next = busy_cnt_reg + (RAW+1)'(cnt_inc) - (RAW+1)'(cnt_dec);
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      busy_reg     <= '0;
      busy_cnt_reg <= '0;
    end else begin
      if (wr_en) begin
        mem_reg[waddr_i] <= wdata_i;
      end
      busy_reg     <= busy_next;
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  assign busy_cnt_o = busy_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [RAW-1:0] ra;
      logic           is_zero;
      logic           fwd;

      assign ra      = rd_addr_i[gi*RAW +: RAW];
      assign is_zero = (ZERO_REG != 0) && (ra == '0);
      assign fwd     = (BYPASS != 0) && wen_i && (ra == waddr_i) && !is_zero;

      assign rd_data_o[gi*DW +: DW] = is_zero ? '0 : (fwd ? wdata_i : mem_reg[ra]);
      assign rd_busy_o[gi]          = !is_zero && !fwd && busy_reg[ra];
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (zero-reg/bypass on, and both off) share the same stimulus.
// Directed vectors, corner sequences and random traffic are checked against an array-based model.
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        rsv;
  logic [4:0]  rsv_addr;

  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic        rsv_ok_a, rsv_ok_b;
  logic [5:0]  cnt_a, cnt_b;

  int n_checks = 0;
  int n_pass   = 0;

  reg_file_sb dut_a (
    .clk(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a),
    .rd_busy_o(rd_busy_a), .wen_i(wen), .waddr_i(waddr), .wdata_i(wdata),
    .rsv_i(rsv), .rsv_addr_i(rsv_addr), .rsv_ok_o(rsv_ok_a), .busy_cnt_o(cnt_a)
  );

  reg_file_sb #(.ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
    .rd_busy_o(rd_busy_b), .wen_i(wen), .waddr_i(waddr), .wdata_i(wdata),
    .rsv_i(rsv), .rsv_addr_i(rsv_addr), .rsv_ok_o(rsv_ok_b), .busy_cnt_o(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state, index 0 = dut_a (ZERO_REG=1, BYPASS=1), index 1 = dut_b (both 0).
  logic [31:0] m_mem  [2][32];
  logic        m_busy [2][32];

  function automatic logic [31:0] m_rd(int d, logic [4:0] a);
    if (d == 0 && a == 0) return 32'h0;
    if (d == 0 && wen && a == waddr) return wdata;
    return m_mem[d][a];
  endfunction

  function automatic logic m_rdb(int d, logic [4:0] a);
    if (d == 0 && a == 0) return 1'b0;
    if (d == 0 && wen && a == waddr) return 1'b0;
    return m_busy[d][a];
  endfunction

  function automatic logic m_ok(int d);
    return rsv && !rst && (!m_busy[d][rsv_addr] || (wen && waddr == rsv_addr));
  endfunction

  function automatic logic [5:0] m_cnt(int d);
    int c = 0;
    for (int i = 0; i < 32; i++) if (m_busy[d][i]) c++;
    return 6'(c);
  endfunction

  task automatic m_step();
    logic ok [2];
    for (int d = 0; d < 2; d++) ok[d] = m_ok(d);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) begin
          m_mem[d][i]  = 32'h0;
          m_busy[d][i] = 1'b0;
        end
      end else begin
        if (wen && !(d == 0 && waddr == 0)) begin
          m_mem[d][waddr]  = wdata;
          m_busy[d][waddr] = 1'b0;
        end
        if (ok[d] && !(d == 0 && rsv_addr == 0)) m_busy[d][rsv_addr] = 1'b1;
      end
    end
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("a_rd_data%0d", k), 64'(rd_data_a[k*32 +: 32]), 64'(m_rd(0, rd_addr[k*5 +: 5])));
      chk($sformatf("b_rd_data%0d", k), 64'(rd_data_b[k*32 +: 32]), 64'(m_rd(1, rd_addr[k*5 +: 5])));
      chk($sformatf("a_rd_busy%0d", k), 64'(rd_busy_a[k]), 64'(m_rdb(0, rd_addr[k*5 +: 5])));
      chk($sformatf("b_rd_busy%0d", k), 64'(rd_busy_b[k]), 64'(m_rdb(1, rd_addr[k*5 +: 5])));
    end
    chk("a_rsv_ok", 64'(rsv_ok_a), 64'(m_ok(0)));
    chk("b_rsv_ok", 64'(rsv_ok_b), 64'(m_ok(1)));
    chk("a_busy_cnt", 64'(cnt_a), 64'(m_cnt(0)));
    chk("b_busy_cnt", 64'(cnt_b), 64'(m_cnt(1)));
  endtask

  // Inputs are already driven and settled; check, then take one edge.
  task automatic cyc();
    check_all();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; wen = 0; waddr = 0; wdata = 0; rsv = 0; rsv_addr = 0;
  endtask

  typedef struct {
    logic        rst, wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rsv;
    logic [4:0]  raddr;
    logic [4:0]  ra0, ra1;
    logic [31:0] e_d0, e_d1;
    logic        e_b0, e_ok;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{0, 1, 7, 32'hDEADBEEF, 0, 0, 7, 7, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 32'h0,        0, 0, 7, 7, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 32'h0,        1, 5, 5, 7, 32'h0,        32'hDEADBEEF, 0, 1, 0};
    tbl[3]  = '{0, 0, 0, 32'h0,        1, 5, 5, 7, 32'h0,        32'hDEADBEEF, 1, 0, 1};
    tbl[4]  = '{0, 1, 5, 32'h1234,     0, 0, 5, 7, 32'h1234,     32'hDEADBEEF, 0, 0, 1};
    tbl[5]  = '{0, 0, 0, 32'h0,        0, 0, 5, 7, 32'h1234,     32'hDEADBEEF, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 32'h0,        1, 9, 9, 7, 32'h0,        32'hDEADBEEF, 0, 1, 0};
    tbl[7]  = '{0, 1, 9, 32'hAA,       1, 9, 9, 7, 32'hAA,       32'hDEADBEEF, 0, 1, 1};
    tbl[8]  = '{0, 0, 0, 32'h0,        0, 0, 9, 7, 32'hAA,       32'hDEADBEEF, 1, 0, 1};
    tbl[9]  = '{0, 1, 0, 32'hFFFF,     0, 0, 0, 7, 32'h0,        32'hDEADBEEF, 0, 0, 1};
    tbl[10] = '{0, 0, 0, 32'h0,        1, 0, 0, 7, 32'h0,        32'hDEADBEEF, 0, 1, 1};
    tbl[11] = '{0, 0, 0, 32'h0,        0, 0, 0, 7, 32'h0,        32'hDEADBEEF, 0, 0, 1};
    tbl[12] = '{0, 1, 9, 32'h55,       0, 0, 9, 7, 32'h55,       32'hDEADBEEF, 0, 0, 1};
    tbl[13] = '{0, 0, 0, 32'h0,        0, 0, 9, 7, 32'h55,       32'hDEADBEEF, 0, 0, 0};
    tbl[14] = '{1, 1, 3, 32'h77,       1, 3, 7, 7, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0};
    tbl[15] = '{0, 0, 0, 32'h0,        0, 0, 7, 3, 32'h0,        32'h0,        0, 0, 0};

    // Initial reset; model starts from the reset state.
    idle();
    rd_addr = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    m_step();
    @(negedge clk);
    idle();

    // After reset every address reads zero and not busy on both ports.
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(31 - a)};
      #2;
      chk("reset_rd0", 64'(rd_data_a[31:0]), 64'h0);
      chk("reset_rd1", 64'(rd_data_a[63:32]), 64'h0);
      chk("reset_busy", 64'(rd_busy_a), 64'h0);
      chk("reset_cnt", 64'(cnt_a), 64'h0);
      cyc();
    end
    $display("reset sweep: 32 addresses read on both ports");

    // Directed vectors for dut_a, with dut_b also tracked by the model.
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; wen = tbl[i].wen; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
      rsv = tbl[i].rsv; rsv_addr = tbl[i].raddr; rd_addr = {tbl[i].ra1, tbl[i].ra0};
      #2;
      $display("vec %0d: rst=%0b wen=%0b wa=%0d wd=%0h rsv=%0b ra=%0d rd=%0d/%0d -> d0=%0h d1=%0h b0=%0b ok=%0b cnt=%0d",
               i, rst, wen, waddr, wdata, rsv, rsv_addr, tbl[i].ra0, tbl[i].ra1,
               rd_data_a[31:0], rd_data_a[63:32], rd_busy_a[0], rsv_ok_a, cnt_a);
      chk($sformatf("vec%0d_d0", i), 64'(rd_data_a[31:0]), 64'(tbl[i].e_d0));
      chk($sformatf("vec%0d_d1", i), 64'(rd_data_a[63:32]), 64'(tbl[i].e_d1));
      chk($sformatf("vec%0d_b0", i), 64'(rd_busy_a[0]), 64'(tbl[i].e_b0));
      chk($sformatf("vec%0d_ok", i), 64'(rsv_ok_a), 64'(tbl[i].e_ok));
      chk($sformatf("vec%0d_cnt", i), 64'(cnt_a), 64'(tbl[i].e_cnt));
      // Without forwarding, the write to 7 shows up one cycle later.
      if (i == 0) chk("nobyp_same_cycle", 64'(rd_data_b[31:0]), 64'h0);
      if (i == 1) chk("nobyp_next_cycle", 64'(rd_data_b[31:0]), 64'hDEADBEEF);
      cyc();
    end
    idle();

    // Reserve every word on dut_b, then reset while still requesting.
    rst = 1;
    #2;
    cyc();
    idle();
    for (int a = 0; a < 32; a++) begin
      rsv = 1; rsv_addr = 5'(a); rd_addr = {5'(a), 5'(a)};
      #2;
      chk("fill_ok_b", 64'(rsv_ok_b), 64'h1);
      cyc();
    end
    rsv = 0;
    #2;
    $display("fill: cnt_a=%0d cnt_b=%0d", cnt_a, cnt_b);
    chk("fill_cnt_b", 64'(cnt_b), 64'd32);
    chk("fill_cnt_a", 64'(cnt_a), 64'd31);
    cyc();
    rst = 1; rsv = 1; rsv_addr = 5;
    #2;
    chk("rst_ok_b", 64'(rsv_ok_b), 64'h0);
    chk("rst_ok_a", 64'(rsv_ok_a), 64'h0);
    chk("rst_cnt_hold", 64'(cnt_b), 64'd32);
    cyc();
    idle();
    #2;
    $display("reset pulse: cnt_b=%0d", cnt_b);
    chk("rst_cnt_b", 64'(cnt_b), 64'd0);
    cyc();

    // Random traffic with address clustering to force collisions.
    for (int n = 0; n < 1500; n++) begin
      rst      = ($urandom_range(0, 63) == 0);
      wen      = rst ? 1'b0 : 1'($urandom_range(0, 1));
      waddr    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      wdata    = $urandom;
      rsv      = 1'($urandom_range(0, 1));
      rsv_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      rd_addr  = {($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? rsv_addr : 5'($urandom_range(0, 31))};
      #2;
      $display("rnd %0d: rst=%0b wen=%0b wa=%0d rsv=%0b ra=%0d ok=%0b/%0b cnt=%0d/%0d",
               n, rst, wen, waddr, rsv, rsv_addr, rsv_ok_a, rsv_ok_b, cnt_a, cnt_b);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
